// File: rtl/instr_decode_pipe.sv
// Instruction decode stage for the 8-bit core.
// Registers the fetched byte into ir and decodes it combinationally into
// register enables and mux selects. Adds a valid/stall handshake with fetch
// and a two-byte long jump (prefix + operand) tracked by a two-state FSM.
module instr_decode_pipe #(
    parameter bit         EXT_EN     = 1'b1,
    parameter logic [7:0] EXT_PREFIX = 8'hCF,
    parameter logic [3:0] IDLE_SRC   = 4'd10
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic [7:0] next_instr,
    input  logic       instr_valid,
    input  logic       stall,
    output logic       instr_ready,
    output logic [7:0] ir,
    output logic [3:0] ir_nibble,
    output logic       dec_valid,
    output logic       ext_pending,
    output logic       jmp,
    output logic       jmp_nz,
    output logic       jmp_long,
    output logic [7:0] ext_operand,
    output logic       i_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic [3:0] source_sel,
    output logic [8:0] reg_en
);

    typedef enum logic {S_DECODE, S_OPERAND} state_t;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       dec_valid_q, dec_valid_d;
    logic       active;

    // Destination field to reg_en bit; dest 4 is the output register at bit 8.
    function automatic logic [8:0] dest_bit(input logic [2:0] d);
        case (d)
            3'd4:    dest_bit = 9'h100;
            default: dest_bit = 9'h001 << d;
        endcase
    endfunction

    // The held instruction takes effect only in cycles where it is valid and not stalled.
    assign active      = dec_valid_q && !stall;
    assign instr_ready = !stall;
    assign ir          = ir_q;
    assign ir_nibble   = ir_q[3:0];
    assign dec_valid   = dec_valid_q;

    // Next-state for ir, valid flag and long-jump FSM; stall freezes everything.
    always_comb begin
        ir_d        = ir_q;
        dec_valid_d = dec_valid_q;
        state_d     = state_q;
        if (!stall) begin
            if (instr_valid) begin
                ir_d        = next_instr;
                dec_valid_d = 1'b1;
            end else begin
                dec_valid_d = 1'b0;
            end
        end
        if (active) begin
            if (state_q == S_OPERAND)
                state_d = S_DECODE;
            else if (EXT_EN && ir_q == EXT_PREFIX)
                state_d = S_OPERAND;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            ir_q        <= 8'h00;
            dec_valid_q <= 1'b0;
            state_q     <= S_DECODE;
        end else begin
            ir_q        <= ir_d;
            dec_valid_q <= dec_valid_d;
            state_q     <= state_d;
        end
    end

    // Output decode: reset override, then quiet defaults, then FSM/opcode decode.
    always_comb begin
        logic [2:0] d;
        logic [2:0] s;
        d           = 3'd0;
        s           = ir_q[2:0];
        reg_en      = 9'h000;
        source_sel  = IDLE_SRC;
        jmp         = 1'b0;
        jmp_nz      = 1'b0;
        jmp_long    = 1'b0;
        ext_operand = 8'h00;
        i_sel       = 1'b1;
        x_sel       = 1'b0;
        y_sel       = 1'b0;
        ext_pending = (state_q == S_OPERAND);
        if (sync_reset) begin
            reg_en      = 9'h1FF;
            i_sel       = 1'b0;
            ext_pending = 1'b0;
        end else if (active) begin
            if (state_q == S_OPERAND) begin
                // Operand byte of a long jump: only the jump target is driven.
                jmp_long    = 1'b1;
                ext_operand = ir_q;
            end else if (EXT_EN && ir_q == EXT_PREFIX) begin
                // Prefix cycle stays quiet; the FSM arms for the operand.
            end else if (!ir_q[7]) begin
                // Load immediate nibble.
                d          = ir_q[6:4];
                reg_en     = dest_bit(d);
                source_sel = 4'd8;
                if (d == 3'd6) i_sel = 1'b0;
                if (d == 3'd7) reg_en[6] = 1'b1;
            end else if (!ir_q[6]) begin
                // Register move; s==d selects a special bus source.
                d      = ir_q[5:3];
                reg_en = dest_bit(d);
                if (s != d)         source_sel = {1'b0, s};
                else if (s == 3'd4) source_sel = 4'd4;
                else                source_sel = 4'd9;
                if (d == 3'd6) i_sel = 1'b0;
                if (d == 3'd7 || s == 3'd7) reg_en[6] = 1'b1;
            end else if (!ir_q[5]) begin
                // ALU op writes r.
                reg_en[4]  = 1'b1;
                x_sel      = ir_q[4];
                y_sel      = ir_q[3];
                source_sel = {1'b0, s};
            end else begin
                jmp        = !ir_q[4];
                jmp_nz     = ir_q[4];
                source_sel = {1'b0, s};
            end
        end
    end

endmodule
